// File: rtl/apb_master_q_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_q_pkg
//  Description : Shared definitions for the queued APB4 master: FSM state
//                encoding, command/response word layouts and width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_master_q_pkg;

    // APB transfer phases
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Response word layout, MSB to LSB: {rdata, err, write}
    localparam int RSP_WRITE_BIT = 0;
    localparam int RSP_ERR_BIT   = 1;
    localparam int RSP_DATA_LSB  = 2;

    // Command word layout, MSB to LSB: {addr, write, wdata, strb}
    function automatic int cmd_width(input int addr_w, input int data_w);
        return addr_w + 1 + data_w + data_w / 8;
    endfunction

    function automatic int rsp_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_q_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy count and a
//                combinational head read. A push on a full FIFO is honoured
//                only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign full  = (count_q == c_FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_q.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_q
//  Description : APB4 master fed by a command FIFO and returning results
//                through a response FIFO. A transfer is only launched when
//                its response is guaranteed a slot, so the APB side never
//                stalls on response backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master_q
    import apb_master_q_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_write,
    output logic                PSELx,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);
    localparam int RSP_W  = rsp_width(DATA_W);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] c_RSP_CAP    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_RSP_CAP_M1 = CNT_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST   = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e       state_q;
    apb_state_e       state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              w_cmd_push;
    logic              w_cmd_pop;
    logic [CMD_W-1:0]  w_cmd_din;
    logic [CMD_W-1:0]  w_cmd_dout;
    logic              w_cmd_full;
    logic              w_cmd_empty;
    logic [CNT_W-1:0]  w_cmd_count;

    logic [ADDR_W-1:0] w_hd_addr;
    logic              w_hd_write;
    logic [DATA_W-1:0] w_hd_wdata;
    logic [STRB_W-1:0] w_hd_strb;

    logic              w_rsp_push;
    logic              w_rsp_pop;
    logic [RSP_W-1:0]  w_rsp_din;
    logic [RSP_W-1:0]  w_rsp_dout;
    logic              w_rsp_full;
    logic              w_rsp_empty;
    logic [CNT_W-1:0]  w_rsp_count;

    logic              w_launch_idle;
    logic              w_launch_next;
    logic              w_tmo_hit;
    logic              w_done;
    logic              w_unused_fifo_status;

    // ---------------------------------------------------------------- FIFOs
    assign cmd_ready  = !w_cmd_full && !reset;
    assign w_cmd_push = cmd_valid && cmd_ready;
    assign w_cmd_din  = {cmd_addr, cmd_write, cmd_wdata, cmd_strb};
    assign {w_hd_addr, w_hd_write, w_hd_wdata, w_hd_strb} = w_cmd_dout;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_cmd_push),
        .pop   (w_cmd_pop),
        .din   (w_cmd_din),
        .dout  (w_cmd_dout),
        .full  (w_cmd_full),
        .empty (w_cmd_empty),
        .count (w_cmd_count)
    );

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rsp_push),
        .pop   (w_rsp_pop),
        .din   (w_rsp_din),
        .dout  (w_rsp_dout),
        .full  (w_rsp_full),
        .empty (w_rsp_empty),
        .count (w_rsp_count)
    );

    // Response fields are forced to zero whenever no response is presented
    assign rsp_valid = !w_rsp_empty && !reset;
    assign w_rsp_pop = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? w_rsp_dout[RSP_DATA_LSB +: DATA_W] : '0;
    assign rsp_err   = rsp_valid && w_rsp_dout[RSP_ERR_BIT];
    assign rsp_write = rsp_valid && w_rsp_dout[RSP_WRITE_BIT];

    // Command FIFO count and response full flag are not needed: the launch
    // rule works from the response count and never overfills that FIFO.
    assign w_unused_fifo_status = &{1'b0, w_cmd_count, w_rsp_full};

    // ------------------------------------------------------- launch/complete
    // A launch from a completing ACCESS must leave room for the response
    // being pushed in that same cycle, hence the tighter bound.
    assign w_launch_idle = !w_cmd_empty && (w_rsp_count < c_RSP_CAP);
    assign w_launch_next = !w_cmd_empty && (w_rsp_count < c_RSP_CAP_M1);
    assign w_tmo_hit     = (TIMEOUT != 0) && !PREADY && (tmo_q == c_TMO_LAST);
    assign w_done        = PREADY || w_tmo_hit;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_launch_idle) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (w_done) state_d = w_launch_next ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: APB phase strobes, FIFO pop/push
    always_comb begin
        PSELx      = 1'b0;
        PENABLE    = 1'b0;
        w_cmd_pop  = 1'b0;
        w_rsp_push = 1'b0;
        case (state_q)
            ST_IDLE:   w_cmd_pop = w_launch_idle;
            ST_SETUP:  PSELx = 1'b1;
            ST_ACCESS: begin
                PSELx      = 1'b1;
                PENABLE    = 1'b1;
                w_rsp_push = w_done;
                w_cmd_pop  = w_done && w_launch_next;
            end
            default: ;
        endcase
    end

    // Response word built from the completing ACCESS cycle
    always_comb begin
        w_rsp_din                = '0;
        w_rsp_din[RSP_WRITE_BIT] = pwrite_q;
        if (w_tmo_hit) begin
            w_rsp_din[RSP_ERR_BIT] = 1'b1;
        end else begin
            w_rsp_din[RSP_ERR_BIT] = PSLVERR;
            if (!pwrite_q) w_rsp_din[RSP_DATA_LSB +: DATA_W] = PRDATA;
        end
    end

    // APB address/data registers load on every pop and hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (w_cmd_pop) begin
            paddr_q  <= w_hd_addr;
            pwrite_q <= w_hd_write;
            pwdata_q <= w_hd_write ? w_hd_wdata : '0;
            pstrb_q  <= w_hd_write ? w_hd_strb  : '0;
        end
    end

    // Wait-state counter: cleared in SETUP, counts PREADY-low ACCESS cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (state_q == ST_SETUP) begin
            tmo_q <= '0;
        end else if ((state_q == ST_ACCESS) && !PREADY) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;
    assign PSTRB  = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_q.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_q
//  Description : Directed bench for apb_master_q. Expected responses are
//                queued when a command is issued; a monitor pops and
//                compares on every rsp handshake. A small APB slave model
//                supplies PREADY/PRDATA/PSLVERR.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_master_q;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        write;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_write;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    int   cyc        = 0;
    int   setup_cnt  = 0;
    int   enable_cnt = 0;
    int   setup_cyc[$];

    // slave model controls
    int   slv_wait  = 0;
    logic slv_stuck = 1'b0;
    logic slv_err   = 1'b0;

    apb_master_q #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_write (rsp_write),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge and tally phases
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (PSELx && !PENABLE) begin
            setup_cnt++;
            setup_cyc.push_back(cyc);
        end
        if (PSELx && PENABLE) enable_cnt++;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] er, input logic ee);
        rsp_t e;
        int   n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        e.rdata = er;
        e.err   = ee;
        e.write = w;
        exp_q.push_back(e);
        tick();
        cmd_valid = 1'b0;
    endtask

    // APB slave: PRDATA = PADDR + 0xDEADBEDF, so address 0x10 reads 0xDEADBEEF
    initial begin : slave
        int acc_n;
        acc_n   = 0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            if (PSELx && PENABLE) begin
                PREADY  = !slv_stuck && (acc_n >= slv_wait);
                PRDATA  = PWRITE ? 32'h0 : PADDR + 32'hDEAD_BEDF;
                PSLVERR = slv_err;
                acc_n++;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = '0;
                PSLVERR = 1'b0;
                acc_n   = 0;
            end
        end
    end

    // Response monitor: compares every handshake against the queue head
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {rsp_rdata, rsp_err, rsp_write}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_word", {rsp_rdata, rsp_err, rsp_write}, {e.rdata, e.err, e.write});
                end
            end
        end
    end

    initial begin : stim
        int   n;
        logic seen;
        logic activity;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;

        // ---- reset state
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_apb", {PSELx, PENABLE, PWRITE, PADDR, PSTRB}, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_write, rsp_rdata}, 0);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        tick();
        chk("rel_idle", PSELx, 0);

        // ---- single write; cycle 0 begins at the accepting edge
        push_cmd(32'hABCD_1234, 1'b1, 32'hFACE_CAFE, 4'hF, 32'h0, 1'b0);
        chk("wr_c0_psel", PSELx, 0);
        tick();
        chk("wr_c1_phase", {PSELx, PENABLE}, 2'b10);
        chk("wr_c1_paddr", PADDR, 32'hABCD_1234);
        chk("wr_c1_pwdata", PWDATA, 32'hFACE_CAFE);
        chk("wr_c1_pwrite", PWRITE, 1);
        tick();
        chk("wr_c2_phase", {PSELx, PENABLE}, 2'b11);
        chk("wr_c2_pstrb", PSTRB, 4'hF);
        chk("wr_c2_rsp_valid", rsp_valid, 0);
        tick();
        chk("wr_c3_rsp_valid", rsp_valid, 1);
        chk("wr_c3_psel", PSELx, 0);
        rsp_ready = 1'b1;
        tick();
        chk("wr_rsp_drained", rsp_valid, 0);

        // ---- read with three wait states
        slv_wait   = 3;
        enable_cnt = 0;
        push_cmd(32'h0000_0010, 1'b0, 32'h1111_2222, 4'hF, 32'hDEAD_BEEF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (PSELx) begin
                seen = 1'b1;
                chk("rd_paddr_stable", PADDR, 32'h10);
                chk("rd_pstrb_zero", PSTRB, 0);
                chk("rd_pwdata_zero", PWDATA, 0);
            end else if (seen) begin
                break;
            end
        end
        chk("rd_access_cycles", enable_cnt, 4);
        slv_wait = 0;
        repeat (2) tick();

        // ---- back-to-back burst of four writes
        cyc = 0;
        setup_cyc.delete();
        push_cmd(32'h0000_0100, 1'b1, 32'h0000_0001, 4'h1, 32'h0, 1'b0);
        push_cmd(32'h0000_0104, 1'b1, 32'h0000_0002, 4'h3, 32'h0, 1'b0);
        push_cmd(32'h0000_0108, 1'b1, 32'h0000_0003, 4'h7, 32'h0, 1'b0);
        push_cmd(32'h0000_010C, 1'b1, 32'h0000_0004, 4'hF, 32'h0, 1'b0);
        repeat (10) tick();
        chk("burst_setups", setup_cyc.size(), 4);
        if (setup_cyc.size() == 4) begin
            chk("burst_first_setup", setup_cyc[0], 2);
            for (int i = 0; i < 3; i++)
                chk("burst_setup_spacing", setup_cyc[i+1] - setup_cyc[i], 2);
        end

        // ---- response backpressure: six reads, only four may issue
        rsp_ready = 1'b0;
        setup_cnt = 0;
        for (int i = 0; i < 6; i++)
            push_cmd(32'h0000_0200 + 32'(i * 4), 1'b0, 32'h0, 4'h0,
                     32'hDEAD_C0DF + 32'(i * 4), 1'b0);
        repeat (20) tick();
        chk("bp_setups_stalled", setup_cnt, 4);
        chk("bp_fsm_idle", PSELx, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("bp_all_responses", exp_q.size(), 0);
        chk("bp_setups_total", setup_cnt, 6);

        // ---- slave error on a write
        slv_err = 1'b1;
        push_cmd(32'h0000_2000, 1'b1, 32'h5555_AAAA, 4'hC, 32'h0, 1'b1);
        repeat (6) tick();
        slv_err = 1'b0;

        // ---- PREADY stuck low: abort after 16 ACCESS cycles
        rsp_ready  = 1'b0;
        slv_stuck  = 1'b1;
        enable_cnt = 0;
        push_cmd(32'h0000_0044, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_access_cycles", enable_cnt, 16);
        chk("tmo_bus_released", PSELx, 0);
        rsp_ready = 1'b1;
        tick();
        chk("tmo_rsp_drained", rsp_valid, 0);

        // ---- reset in ACCESS with two commands still queued
        push_cmd(32'h0000_0300, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        push_cmd(32'h0000_0304, 1'b1, 32'h7777_8888, 4'hF, 32'h0, 1'b0);
        push_cmd(32'h0000_0308, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        n = 0;
        while (!PENABLE && n < 20) begin
            tick();
            n++;
        end
        chk("mid_in_access", PENABLE, 1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_apb", {PSELx, PENABLE, PWRITE, PADDR, PSTRB}, 0);
        chk("mid_rst_pwdata", PWDATA, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_write, rsp_rdata}, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        reset     = 1'b0;
        slv_stuck = 1'b0;
        activity  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (PSELx || rsp_valid) activity = 1'b1;
        end
        chk("mid_fifos_empty", activity, 0);
        chk("mid_cmd_ready", cmd_ready, 1);

        // ---- normal operation after the mid-transfer reset
        push_cmd(32'h0000_0020, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEFF, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("final_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_q.md
# apb_master_q

Parameterised APB4 master with queued commands and queued responses. It decouples the system-side command interface from the APB bus through a command FIFO and a response FIFO. The block supports reads and writes, byte strobes, PSLVERR capture, back-to-back transfers and a PREADY timeout. It is the bus-side bridge between internal agents and APB slaves in the peripheral subsystem.

## Interface
- ADDR_W, 32, PADDR / cmd_addr width
- DATA_W, 32, data width; must be 8, 16 or 32
- DEPTH, 4, entries in each FIFO; power of 2, ≥ 2
- TIMEOUT, 16, ACCESS cycles with PREADY low before abort; 0 disables the timeout
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_addr  in  ADDR_W  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte strobes, writes only
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and aborts)
- rsp_err  out  1  PSLVERR, or timeout abort
- rsp_write  out  1  echo of the command's cmd_write
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- **Command push:** on cmd_valid && cmd_ready, {addr, write, wdata, strb} is pushed into the command FIFO.
- **FSM states:** IDLE, SETUP, ACCESS.
  - IDLE → SETUP when the command FIFO is non-empty and the response FIFO has a free slot. The head command is popped and registered onto PADDR, PWRITE, PWDATA and PSTRB.
  - SETUP → ACCESS unconditionally.
  - ACCESS → completion when PREADY = 1, or when the timeout fires.
  - On completion, go to SETUP (back-to-back) if the launch condition holds; otherwise go to IDLE.
- **Launch condition:**
  - From IDLE: command FIFO non-empty and rsp_count < DEPTH.
  - From ACCESS completion: command FIFO non-empty and rsp_count + 1 < DEPTH.
  - rsp_count is the registered occupancy. A same-cycle rsp pop is ignored, which is conservative. This rule guarantees the response FIFO never overflows and APB never stalls on response backpressure.
- **Completion writes the response FIFO:**
  - Read: {PRDATA, PSLVERR, 0}.
  - Write: {0, PSLVERR, 1}.
  - Timeout: {0, 1, PWRITE}.
- **APB output rules:**
  - PSELx = 1 in SETUP and ACCESS.
  - PENABLE = 1 in ACCESS only.
  - PADDR, PWRITE, PWDATA and PSTRB hold stable from SETUP through the completing ACCESS cycle.
  - In IDLE, PADDR, PWRITE, PWDATA and PSTRB retain their last values.
  - Reads drive PSTRB = 0 and PWDATA = 0.
- **Timeout:** a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY = 0. When it equals TIMEOUT, the transfer completes as an abort. A PREADY arriving later is ignored.
- **Ordering:** responses are returned strictly in command order.

## Timing
- **Reset values:** while reset is high and after release:
  - PSELx = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0, PSTRB = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_write = 0.
  - cmd_ready = 0 while reset is high; 1 after release.
  - Both FIFOs are emptied and the FSM returns to IDLE.
- **Reset mid-transfer:** the transfer is dropped, no response is produced, and PSELx/PENABLE fall on the next edge.
- **Latency:**
  - Command accepted in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2.
  - With PREADY = 1 in cycle 2, rsp_valid = 1 in cycle 3.
  - Each PREADY-low cycle adds one cycle.
- **Throughput:** back-to-back zero-wait transfers achieve 2 cycles/transfer; the next SETUP coincides with the cycle after completion.
- **FIFO boundaries:**
  - Command FIFO full → cmd_ready = 0.
  - A simultaneous push and pop on a full command FIFO is not allowed; cmd_ready is based on the registered count.
  - Response FIFO supports a simultaneous push and pop at any occupancy.
- **Timeout timing:** with TIMEOUT = T, the abort completes at the T-th consecutive PREADY-low ACCESS cycle. The abort response is visible in the next cycle.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, SETUP, ACCESS).
  - Response field layout {rdata, err, write}.
  - Command field layout {addr, write, wdata, strb}.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; ports clk, reset, push, pop, din, dout, full, empty, count):
  - One instance for commands, width ADDR_W + 1 + DATA_W + DATA_W/8.
  - One instance for responses, width DATA_W + 2.
- Top level contains the FSM, the APB output registers and the timeout counter.

## Test plan
- **Single write:** cmd write 0xABCD_1234 / 0xFACE_CAFE, strb 0xF, PREADY = 1 immediately → PSELx in cycle 1, PENABLE in cycle 2, PSTRB = 0xF, rsp {rdata 0, err 0, write 1} in cycle 3.
- **Read with wait states:** read 0x10, PREADY low for 3 ACCESS cycles, PRDATA = 0xDEAD_BEEF → PADDR stable throughout, rsp_rdata = 0xDEAD_BEEF, PSTRB = 0.
- **Back-to-back burst:** 4 writes pushed in consecutive cycles, PREADY tied 1, rsp_ready = 1 → SETUP every 2 cycles, no IDLE gap, 4 responses in order.
- **Response backpressure:** DEPTH = 4, rsp_ready = 0, 6 commands queued → exactly 4 transfers issue, then the FSM stays IDLE; raising rsp_ready resumes the remaining 2.
- **Error and timeout:**
  - PSLVERR = 1 on a write → rsp_err = 1.
  - TIMEOUT = 16 with PREADY stuck 0 → abort after 16 ACCESS cycles, rsp_err = 1, rsp_rdata = 0.
- **Reset mid-ACCESS with 2 commands queued:** all outputs return to reset values, no rsp_valid, and the FIFOs are empty afterwards.
